nn_train_ctrl: RTL and testbench

NN_TRAIN_CTRL -- requirements
Module: nn_train_ctrl

---
 rtl/nn_pkg.sv | 55 +++++
 rtl/nn_err_acc.sv | 59 +++++
 rtl/nn_train_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_nn_train_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// nn_pkg -- shared definitions for the training controller.
// Holds the datapath widths, the controller state encoding and the
// absolute-difference / saturating-add helpers used by the error accumulator.
package nn_pkg;

    localparam int DATA_W = 16;  // signed Q6.10 sample / core data
    localparam int FRAC_W = 10;  // fractional bits of the Q6.10 format
    localparam int ERR_W  = 24;  // epoch error accumulator width
    localparam int IDX_W  = 4;   // sample index / memory address width
    localparam int CNT_W  = 16;  // epoch counter width

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_LOAD    = 4'd2,
        ST_ISSUE   = 4'd3,
        ST_WAIT    = 4'd4,
        ST_CAPTURE = 4'd5,
        ST_NEXT    = 4'd6,
        ST_DONE    = 4'd7,
        ST_ERR     = 4'd8
    } nn_state_t;

    // |a - b| for two signed DATA_W values. The difference needs DATA_W+1 bits,
    // but its magnitude never exceeds 2^DATA_W - 1, so it fits DATA_W unsigned.
    function automatic logic [DATA_W-1:0] abs_diff(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W:0] diff;
        logic [DATA_W:0] neg_diff;
        diff     = {a[DATA_W-1], a} - {b[DATA_W-1], b};
        neg_diff = (~diff) + {{DATA_W{1'b0}}, 1'b1};
        if (diff[DATA_W]) begin
            abs_diff = neg_diff[DATA_W-1:0];
        end else begin
            abs_diff = diff[DATA_W-1:0];
        end
    endfunction

    // acc + inc, clamped to all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_add(
        input logic [ERR_W-1:0]  acc,
        input logic [DATA_W:0]   inc
    );
        logic [ERR_W:0] sum;
        sum = {1'b0, acc} + {{(ERR_W-DATA_W){1'b0}}, inc};
        if (sum[ERR_W]) begin
            sat_add = {ERR_W{1'b1}};
        end else begin
            sat_add = sum[ERR_W-1:0];
        end
    endfunction

endpackage

// File: rtl/nn_err_acc.sv
// nn_err_acc -- per-epoch absolute error accumulator.
// Ports:
//   clk, res        clock, asynchronous active-low reset
//   add_en          add |a3_1-t_1| + |a3_2-t_2| to the running sum
//   clear           zero the running sum
//   snap            copy the running sum to epoch_err (uses pre-clear value)
//   a3_1, a3_2      core outputs for the current sample (Q6.10)
//   t_1, t_2        targets for the current sample (Q6.10)
//   epoch_err       snapshot of the last completed epoch's error
module nn_err_acc
    import nn_pkg::*;
(
    input  logic              clk,
    input  logic              res,
    input  logic              add_en,
    input  logic              clear,
    input  logic              snap,
    input  logic [DATA_W-1:0] a3_1,
    input  logic [DATA_W-1:0] a3_2,
    input  logic [DATA_W-1:0] t_1,
    input  logic [DATA_W-1:0] t_2,
    output logic [ERR_W-1:0]  epoch_err
);

    logic [ERR_W-1:0]  acc_r;
    logic [ERR_W-1:0]  epoch_err_r;
    logic [DATA_W-1:0] abs_1_s;
    logic [DATA_W-1:0] abs_2_s;
    logic [DATA_W:0]   smp_err_s;
    logic [ERR_W-1:0]  acc_next_s;

    // Sample error and the saturated next value of the running sum.
    always_comb begin
        abs_1_s    = abs_diff(a3_1, t_1);
        abs_2_s    = abs_diff(a3_2, t_2);
        smp_err_s  = {1'b0, abs_1_s} + {1'b0, abs_2_s};
        acc_next_s = sat_add(acc_r, smp_err_s);
    end

    // Running sum and epoch snapshot registers.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            acc_r       <= {ERR_W{1'b0}};
            epoch_err_r <= {ERR_W{1'b0}};
        end else begin
            if (snap) begin
                epoch_err_r <= acc_r;
            end
            if (clear) begin
                acc_r <= {ERR_W{1'b0}};
            end else if (add_en) begin
                acc_r <= acc_next_s;
            end
        end
    end

    assign epoch_err = epoch_err_r;

endmodule

// File: rtl/nn_train_ctrl.sv
// nn_train_ctrl -- sequences training samples through a network core.
// For every epoch each sample is fetched from sample memory, handed to the
// core, the core's outputs are reported and the absolute error is summed.
// Ports:
//   clk, res                 clock, asynchronous active-low reset
//   start, abort             run control (start sampled in IDLE/DONE/ERR)
//   num_epochs               epochs to run, latched at start
//   smp_addr                 sample memory address (1-cycle read latency)
//   smp_k_1/2, smp_t_1/2     sample inputs / targets (Q6.10)
//   core_update_coeff        one-cycle request to the core
//   core_k_1/2               inputs presented to the core
//   core_finish, core_a3_1/2 core completion and outputs
//   out_valid, out_a3_1/2, out_idx  per-sample result pulse
//   epoch_cnt, epoch_err     completed epochs, last epoch's error sum
//   busy, done, err          status
module nn_train_ctrl
    import nn_pkg::*;
#(
    parameter int NUM_SAMPLES = 4,
    parameter int TIMEOUT     = 1023
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  num_epochs,
    output logic [IDX_W-1:0]  smp_addr,
    input  logic [DATA_W-1:0] smp_k_1,
    input  logic [DATA_W-1:0] smp_k_2,
    input  logic [DATA_W-1:0] smp_t_1,
    input  logic [DATA_W-1:0] smp_t_2,
    output logic              core_update_coeff,
    output logic [DATA_W-1:0] core_k_1,
    output logic [DATA_W-1:0] core_k_2,
    input  logic              core_finish,
    input  logic [DATA_W-1:0] core_a3_1,
    input  logic [DATA_W-1:0] core_a3_2,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_a3_1,
    output logic [DATA_W-1:0] out_a3_2,
    output logic [IDX_W-1:0]  out_idx,
    output logic [CNT_W-1:0]  epoch_cnt,
    output logic [ERR_W-1:0]  epoch_err,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_SAMPLES - 1);

    nn_state_t          state_r;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   smp_addr_r;
    logic [CNT_W-1:0]   num_epochs_r;
    logic [CNT_W-1:0]   epoch_cnt_r;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic [DATA_W-1:0]  k_1_r, k_2_r, t_1_r, t_2_r;
    logic [DATA_W-1:0]  a3_1_r, a3_2_r;
    logic [DATA_W-1:0]  out_a3_1_r, out_a3_2_r;
    logic [IDX_W-1:0]   out_idx_r;
    logic               out_valid_r;
    logic               update_r;
    logic               busy_r, done_r, err_r;

    logic               aborting_s;
    logic               last_smp_s;
    logic [CNT_W-1:0]   epoch_inc_s;
    logic               run_start_s;
    logic               acc_add_s;
    logic               epoch_end_s;
    logic               acc_clear_s;

    // Accumulator controls act on the same edge as the FSM transition,
    // so they are decoded combinationally from the current state; abort
    // suppresses every one of them.
    always_comb begin
        aborting_s  = (state_r != ST_IDLE) && abort;
        last_smp_s  = (idx_r == LAST_IDX);
        epoch_inc_s = epoch_cnt_r + 16'd1;
        run_start_s = (state_r == ST_IDLE) && start && (num_epochs != 16'd0);
        acc_add_s   = (state_r == ST_CAPTURE) && !abort;
        epoch_end_s = (state_r == ST_NEXT) && !abort && last_smp_s;
        acc_clear_s = run_start_s || epoch_end_s;
    end

    // Controller FSM with all status and datapath outputs registered.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_r      <= ST_IDLE;
            idx_r        <= {IDX_W{1'b0}};
            smp_addr_r   <= {IDX_W{1'b0}};
            num_epochs_r <= {CNT_W{1'b0}};
            epoch_cnt_r  <= {CNT_W{1'b0}};
            wait_cnt_r   <= {WAIT_W{1'b0}};
            k_1_r        <= {DATA_W{1'b0}};
            k_2_r        <= {DATA_W{1'b0}};
            t_1_r        <= {DATA_W{1'b0}};
            t_2_r        <= {DATA_W{1'b0}};
            a3_1_r       <= {DATA_W{1'b0}};
            a3_2_r       <= {DATA_W{1'b0}};
            out_a3_1_r   <= {DATA_W{1'b0}};
            out_a3_2_r   <= {DATA_W{1'b0}};
            out_idx_r    <= {IDX_W{1'b0}};
            out_valid_r  <= 1'b0;
            update_r     <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            update_r    <= 1'b0;
            out_valid_r <= 1'b0;
            if (aborting_s) begin
                // Counters and the epoch snapshot are deliberately kept.
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start) begin
                            err_r  <= 1'b0;
                            done_r <= 1'b0;
                            if (num_epochs == 16'd0) begin
                                state_r <= ST_DONE;
                                done_r  <= 1'b1;
                            end else begin
                                num_epochs_r <= num_epochs;
                                epoch_cnt_r  <= {CNT_W{1'b0}};
                                idx_r        <= {IDX_W{1'b0}};
                                smp_addr_r   <= {IDX_W{1'b0}};
                                busy_r       <= 1'b1;
                                state_r      <= ST_FETCH;
                            end
                        end
                    end
                    ST_FETCH: begin
                        state_r <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        // Memory data is valid now, one cycle after the address.
                        k_1_r    <= smp_k_1;
                        k_2_r    <= smp_k_2;
                        t_1_r    <= smp_t_1;
                        t_2_r    <= smp_t_2;
                        update_r <= 1'b1;
                        state_r  <= ST_ISSUE;
                    end
                    ST_ISSUE: begin
                        wait_cnt_r <= {WAIT_W{1'b0}};
                        state_r    <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (core_finish) begin
                            a3_1_r  <= core_a3_1;
                            a3_2_r  <= core_a3_2;
                            state_r <= ST_CAPTURE;
                        end else if (wait_cnt_r == WAIT_LAST) begin
                            err_r   <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= ST_ERR;
                        end else begin
                            wait_cnt_r <= wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
                        end
                    end
                    ST_CAPTURE: begin
                        out_a3_1_r  <= a3_1_r;
                        out_a3_2_r  <= a3_2_r;
                        out_idx_r   <= idx_r;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_NEXT;
                    end
                    ST_NEXT: begin
                        if (!last_smp_s) begin
                            idx_r      <= idx_r + 4'd1;
                            smp_addr_r <= idx_r + 4'd1;
                            state_r    <= ST_FETCH;
                        end else begin
                            idx_r       <= {IDX_W{1'b0}};
                            smp_addr_r  <= {IDX_W{1'b0}};
                            epoch_cnt_r <= epoch_inc_s;
                            if (epoch_inc_s == num_epochs_r) begin
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                                state_r <= ST_DONE;
                            end else begin
                                state_r <= ST_FETCH;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (start) begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_ERR: begin
                        if (start) begin
                            state_r <= ST_IDLE;
                        end
                    end
                    default: begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    nn_err_acc u_err_acc (
        .clk       (clk),
        .res       (res),
        .add_en    (acc_add_s),
        .clear     (acc_clear_s),
        .snap      (epoch_end_s),
        .a3_1      (a3_1_r),
        .a3_2      (a3_2_r),
        .t_1       (t_1_r),
        .t_2       (t_2_r),
        .epoch_err (epoch_err)
    );

    assign smp_addr          = smp_addr_r;
    assign core_update_coeff = update_r;
    assign core_k_1          = k_1_r;
    assign core_k_2          = k_2_r;
    assign out_valid         = out_valid_r;
    assign out_a3_1          = out_a3_1_r;
    assign out_a3_2          = out_a3_2_r;
    assign out_idx           = out_idx_r;
    assign epoch_cnt         = epoch_cnt_r;
    assign busy              = busy_r;
    assign done              = done_r;
    assign err               = err_r;

endmodule

// File: tb/tb_nn_train_ctrl.sv
// tb_nn_train_ctrl -- scoreboard bench for nn_train_ctrl.
// Stimulus pushes expected per-sample results into a queue; a monitor pops
// and compares them whenever out_valid is seen. Status values are checked
// directly against hand-computed constants.
module tb_nn_train_ctrl;
    import nn_pkg::*;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] num_epochs = 16'd0;
    logic [3:0]  smp_addr;
    logic [15:0] smp_k_1, smp_k_2, smp_t_1, smp_t_2;
    logic        core_update_coeff;
    logic [15:0] core_k_1, core_k_2;
    logic        core_finish;
    logic [15:0] core_a3_1, core_a3_2;
    logic        out_valid;
    logic [15:0] out_a3_1, out_a3_2;
    logic [3:0]  out_idx;
    logic [15:0] epoch_cnt;
    logic [23:0] epoch_err;
    logic        busy, done, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nn_train_ctrl #(.NUM_SAMPLES(4), .TIMEOUT(1023)) dut (
        .clk(clk), .res(res), .start(start), .abort(abort),
        .num_epochs(num_epochs), .smp_addr(smp_addr),
        .smp_k_1(smp_k_1), .smp_k_2(smp_k_2), .smp_t_1(smp_t_1), .smp_t_2(smp_t_2),
        .core_update_coeff(core_update_coeff), .core_k_1(core_k_1), .core_k_2(core_k_2),
        .core_finish(core_finish), .core_a3_1(core_a3_1), .core_a3_2(core_a3_2),
        .out_valid(out_valid), .out_a3_1(out_a3_1), .out_a3_2(out_a3_2), .out_idx(out_idx),
        .epoch_cnt(epoch_cnt), .epoch_err(epoch_err),
        .busy(busy), .done(done), .err(err)
    );

    // Sample memory with one cycle of read latency.
    logic [15:0] mem_k1[4], mem_k2[4], mem_t1[4], mem_t2[4];
    always @(posedge clk) begin
        smp_k_1 <= mem_k1[smp_addr[1:0]];
        smp_k_2 <= mem_k2[smp_addr[1:0]];
        smp_t_1 <= mem_t1[smp_addr[1:0]];
        smp_t_2 <= mem_t2[smp_addr[1:0]];
    end

    // Core model: finishes 10 cycles after a request; echoes its inputs or
    // returns fixed values.
    logic        finish_en = 1'b1;
    logic        fixed_mode = 1'b0;
    logic [15:0] fix_a1 = 16'h0000;
    logic [15:0] fix_a2 = 16'h0000;
    int          cd;
    always @(posedge clk or negedge res) begin
        if (!res) begin
            cd          <= 0;
            core_finish <= 1'b0;
        end else begin
            core_finish <= (cd == 1) && finish_en;
            if (core_update_coeff) cd <= 10;
            else if (cd > 0)       cd <= cd - 1;
        end
    end
    assign core_a3_1 = fixed_mode ? fix_a1 : core_k_1;
    assign core_a3_2 = fixed_mode ? fix_a2 : core_k_2;

    int upd_cnt = 0;
    int ov_cnt  = 0;
    always @(posedge clk) begin
        if (res && core_update_coeff) upd_cnt <= upd_cnt + 1;
        if (res && out_valid)         ov_cnt  <= ov_cnt + 1;
    end

    typedef struct packed {
        logic [3:0]  idx;
        logic [15:0] a1;
        logic [15:0] a2;
    } exp_t;
    exp_t sb_q[$];

    // Monitor: every out_valid pulse must match the oldest expected entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (res && out_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got idx=%0d a3_1=%h a3_2=%h, required no out_valid",
                         out_idx, out_a3_1, out_a3_2);
            end else begin
                e = sb_q.pop_front();
                if ({out_idx, out_a3_1, out_a3_2} !== e) begin
                    errors++;
                    $display("FAIL out_sample: got idx=%0d a3_1=%h a3_2=%h, required idx=%0d a3_1=%h a3_2=%h",
                             out_idx, out_a3_1, out_a3_2, e.idx, e.a1, e.a2);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Pulse start so the DUT samples it on the next rising edge; returns #1 after that edge.
    task automatic do_start(input logic [15:0] n);
        @(negedge clk);
        num_epochs = n;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max);
        for (int i = 0; i < max; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    task automatic load_mem_echo();
        mem_k1[0] = 16'h0100; mem_k2[0] = 16'h0200; mem_t1[0] = 16'h0000; mem_t2[0] = 16'h0000;
        mem_k1[1] = 16'hFF00; mem_k2[1] = 16'h0000; mem_t1[1] = 16'h0100; mem_t2[1] = 16'h0000;
        mem_k1[2] = 16'h7FFF; mem_k2[2] = 16'h8000; mem_t1[2] = 16'h8000; mem_t2[2] = 16'h7FFF;
        mem_k1[3] = 16'h0400; mem_k2[3] = 16'h0000; mem_t1[3] = 16'h0400; mem_t2[3] = 16'h0010;
        fixed_mode = 1'b0;
    endtask

    task automatic push_echo_epoch();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.idx = 4'(i);
            e.a1  = mem_k1[i];
            e.a2  = mem_k2[i];
            sb_q.push_back(e);
        end
    endtask

    // Per-epoch error of the echo memory: 0x300 + 0x200 + 0x1FFFE + 0x10.
    localparam logic [31:0] ECHO_ERR = 32'h0002050E;

    initial begin
        int   u0;
        int   ov0;
        logic got;
        exp_t e;

        load_mem_echo();
        #12;
        check("reset_busy",      {31'd0, busy}, 32'd0);
        check("reset_done",      {31'd0, done}, 32'd0);
        check("reset_err",       {31'd0, err}, 32'd0);
        check("reset_epoch_cnt", {16'd0, epoch_cnt}, 32'd0);
        check("reset_update",    {31'd0, core_update_coeff}, 32'd0);
        @(negedge clk);
        res = 1'b1;

        // Two epochs, echo core: latency, pulse width, 8 ordered results.
        push_echo_epoch();
        push_echo_epoch();
        u0 = upd_cnt;
        do_start(16'd2);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        check("update_not_early", {31'd0, core_update_coeff}, 32'd0);
        @(posedge clk); #1;
        check("update_latency", {31'd0, core_update_coeff}, 32'd1);
        @(posedge clk); #1;
        check("update_one_cycle", {31'd0, core_update_coeff}, 32'd0);
        wait_done("run2_done", 400);
        check("run2_epoch_cnt", {16'd0, epoch_cnt}, 32'd2);
        check("run2_epoch_err", {8'd0, epoch_err}, ECHO_ERR);
        check("run2_busy", {31'd0, busy}, 32'd0);
        check("run2_updates", upd_cnt - u0, 32'd8);
        check("run2_sb_empty", sb_q.size(), 32'd0);
        do_start(16'd0);

        // Fixed core outputs: 4 * (0x400 + 0x800) = 0x3000.
        for (int i = 0; i < 4; i++) begin
            mem_k1[i] = 16'h0111; mem_k2[i] = 16'h0222;
            mem_t1[i] = 16'h0000; mem_t2[i] = 16'h0400;
            e.idx = 4'(i); e.a1 = 16'h0400; e.a2 = 16'hFC00;
            sb_q.push_back(e);
        end
        fixed_mode = 1'b1; fix_a1 = 16'h0400; fix_a2 = 16'hFC00;
        do_start(16'd1);
        wait_done("fixed_done", 300);
        check("fixed_epoch_err", {8'd0, epoch_err}, 32'h00003000);
        check("fixed_epoch_cnt", {16'd0, epoch_cnt}, 32'd1);
        do_start(16'd0);

        // Core never finishes: ERR after exactly 1023 WAIT cycles.
        finish_en = 1'b0;
        u0 = upd_cnt;
        do_start(16'd1);
        repeat (1025) @(posedge clk);
        #1;
        check("err_before_timeout", {31'd0, err}, 32'd0);
        check("busy_before_timeout", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        check("err_at_timeout", {31'd0, err}, 32'd1);
        check("busy_at_timeout", {31'd0, busy}, 32'd0);
        check("timeout_updates", upd_cnt - u0, 32'd1);
        do_start(16'd0);
        finish_en = 1'b1;

        // Abort coinciding with core_finish in epoch 2.
        load_mem_echo();
        push_echo_epoch();
        do_start(16'd2);
        for (int i = 0; i < 300; i++) begin
            if (epoch_cnt == 16'd1) break;
            @(negedge clk);
        end
        check("abort_epoch1_reached", {16'd0, epoch_cnt}, 32'd1);
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (core_finish) begin
                got = 1'b1;
                break;
            end
        end
        check("abort_finish_seen", {31'd0, got}, 32'd1);
        abort = 1'b1;
        ov0 = ov_cnt;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_out", ov_cnt, ov0);
        check("abort_epoch_cnt", {16'd0, epoch_cnt}, 32'd1);
        check("abort_epoch_err", {8'd0, epoch_err}, ECHO_ERR);
        check("abort_no_update", {31'd0, core_update_coeff}, 32'd0);

        // Zero epochs: DONE one cycle after start, no core request.
        u0 = upd_cnt;
        do_start(16'd0);
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_busy", {31'd0, busy}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("zero_updates", upd_cnt - u0, 32'd0);
        do_start(16'd0);

        // Reset in the middle of WAIT, then a clean rerun.
        do_start(16'd1);
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        #1;
        res = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_epoch_err", {8'd0, epoch_err}, 32'd0);
        check("midrst_core_k_1", {16'd0, core_k_1}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        res = 1'b1;
        push_echo_epoch();
        do_start(16'd1);
        wait_done("rerun_done", 300);
        check("rerun_epoch_cnt", {16'd0, epoch_cnt}, 32'd1);
        check("rerun_epoch_err", {8'd0, epoch_err}, ECHO_ERR);
        repeat (3) @(posedge clk);
        #1;
        check("final_sb_empty", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
